// File: rtl/hazard_ctrl.sv
// Load-use and branch-operand hazard controller: decides how many cycles the
// IF/ID stage must be held, flushes IF/ID on taken control flow, and counts both.
module hazard_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        IDRs,
  input  logic [4:0]        IDRt,
  input  logic              IDUsesRs,
  input  logic              IDUsesRt,
  input  logic              IDIsBranch,
  input  logic              IDIsJump,
  input  logic              IDBranchTaken,
  input  logic              EXMemRead,
  input  logic              EXRegWrite,
  input  logic [4:0]        EXRd,
  input  logic              MEMMemRead,
  input  logic [4:0]        MEMRd,
  output logic              hold,
  output logic              flush,
  output logic              PCWrite,
  output logic              IDEXBubble,
  output logic [DATA_W-1:0] StallCycles,
  output logic [DATA_W-1:0] FlushCount
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state, state_nxt;
  logic [1:0] remain, remain_nxt;
  logic [1:0] need;
  logic       hold_c;
  logic       ex_hit, mem_hit, needs_in_id, redirect;

  function automatic logic reads_reg(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rs,
                                     input logic use_rt);
    return (rd != 5'd0) && ((use_rs && rs == rd) || (use_rt && rt == rd));
  endfunction

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + DATA_W'(1);
  endfunction

  assign ex_hit      = reads_reg(EXRd, IDRs, IDRt, IDUsesRs, IDUsesRt);
  assign mem_hit     = reads_reg(MEMRd, IDRs, IDRt, IDUsesRs, IDUsesRt);
  // Branches and jr resolve in ID, so they need their operands one stage earlier.
  assign needs_in_id = IDIsBranch || (IDIsJump && IDUsesRs);
  assign redirect    = IDIsJump || (IDIsBranch && IDBranchTaken);

  always_comb begin
    need = 2'd0;
    if (needs_in_id && EXMemRead && ex_hit)
      need = 2'd2;
    else if ((EXMemRead && ex_hit) ||
             (needs_in_id && EXRegWrite && ex_hit) ||
             (needs_in_id && MEMMemRead && mem_hit))
      need = 2'd1;
  end

  // A STALL with Remain exhausted behaves exactly like RUN.
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    hold_c     = 1'b0;
    if (state == STALL && remain != 2'd0) begin
      hold_c     = 1'b1;
      remain_nxt = remain - 2'd1;
    end else if (need != 2'd0) begin
      hold_c     = 1'b1;
      state_nxt  = STALL;
      remain_nxt = need - 2'd1;
    end else begin
      state_nxt  = RUN;
    end
  end

  assign hold       = reset && hold_c;
  assign flush      = reset && !hold_c && redirect;
  assign PCWrite    = !hold;
  assign IDEXBubble = hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      remain      <= 2'd0;
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
      if (hold)  StallCycles <= sat_inc(StallCycles);
      if (flush) FlushCount  <= sat_inc(FlushCount);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios, random traffic
// with random resets, and a long stall run for counter saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IDRs, IDRt, EXRd, MEMRd;
  logic        IDUsesRs, IDUsesRt, IDIsBranch, IDIsJump, IDBranchTaken;
  logic        EXMemRead, EXRegWrite, MEMMemRead;
  logic        hold, flush, PCWrite, IDEXBubble;
  logic [15:0] StallCycles, FlushCount;

  typedef struct packed {
    logic        h;
    logic        f;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: cycles of forced hold still owed, and counter values.
  int   owed = 0;
  int   m_sc = 0;
  int   m_fc = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .IDIsBranch(IDIsBranch), .IDIsJump(IDIsJump), .IDBranchTaken(IDBranchTaken),
    .EXMemRead(EXMemRead), .EXRegWrite(EXRegWrite), .EXRd(EXRd),
    .MEMMemRead(MEMMemRead), .MEMRd(MEMRd),
    .hold(hold), .flush(flush), .PCWrite(PCWrite), .IDEXBubble(IDEXBubble),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic bit uses(input logic [4:0] rd);
    if (rd == 0) return 0;
    return (IDUsesRs && IDRs == rd) || (IDUsesRt && IDRt == rd);
  endfunction

  function automatic int stall_need();
    bit early = IDIsBranch || (IDIsJump && IDUsesRs);
    int n = 0;
    if (EXMemRead && uses(EXRd)) n = early ? 2 : 1;
    if (early && EXRegWrite && !EXMemRead && uses(EXRd) && n < 1) n = 1;
    if (early && MEMMemRead && uses(MEMRd) && n < 1) n = 1;
    return n;
  endfunction

  // Predict this cycle's outputs from the current inputs, queue them, then advance one edge.
  task automatic step();
    exp_t e;
    int   n;
    if (!reset) begin
      owed = 0; m_sc = 0; m_fc = 0;
      e = '{h: 1'b0, f: 1'b0, sc: 16'd0, fc: 16'd0};
    end else begin
      n = stall_need();
      e.sc = 16'(m_sc);
      e.fc = 16'(m_fc);
      if (owed > 0) begin
        e.h = 1'b1; owed--;
      end else if (n > 0) begin
        e.h = 1'b1; owed = n - 1;
      end else begin
        e.h = 1'b0;
      end
      e.f = !e.h && (IDIsJump || (IDIsBranch && IDBranchTaken));
      if (e.h && m_sc < 65535) m_sc++;
      if (e.f && m_fc < 65535) m_fc++;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    IDRs = 0; IDRt = 0; IDUsesRs = 0; IDUsesRt = 0;
    IDIsBranch = 0; IDIsJump = 0; IDBranchTaken = 0;
    EXMemRead = 0; EXRegWrite = 0; EXRd = 0; MEMMemRead = 0; MEMRd = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // lw $3 in EX while beq in ID reads $3 through Rt, taken.
  task automatic lw_beq_setup();
    clear_inputs();
    IDIsBranch = 1; IDUsesRs = 1; IDRs = 5'd7; IDUsesRt = 1; IDRt = 5'd3; IDBranchTaken = 1;
    EXMemRead = 1; EXRegWrite = 1; EXRd = 5'd3;
  endtask

  task automatic lw_moves_to_mem();
    EXMemRead = 0; EXRegWrite = 0; EXRd = 0;
    MEMMemRead = 1; MEMRd = 5'd3;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("hold", hold, e.h);
      check("flush", flush, e.f);
      check("PCWrite", PCWrite, !e.h);
      check("IDEXBubble", IDEXBubble, e.h);
      check("StallCycles", StallCycles, e.sc);
      check("FlushCount", FlushCount, e.fc);
      check("hold_and_flush", hold & flush, 0);
    end
  end

  initial begin
    reset = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b1;

    // load-use on a plain ALU instruction: one bubble
    clear_inputs();
    IDUsesRs = 1; IDRs = 5'd2; IDUsesRt = 1; IDRt = 5'd5;
    EXMemRead = 1; EXRegWrite = 1; EXRd = 5'd2;
    step();
    EXMemRead = 0; EXRegWrite = 0; EXRd = 0; MEMMemRead = 1; MEMRd = 5'd2;
    step();
    clear_inputs();
    step();

    // load feeding a branch: two holds, then the taken branch flushes
    pulse_reset();
    lw_beq_setup();
    step();
    lw_moves_to_mem();
    step();
    MEMMemRead = 0; MEMRd = 0;
    step();
    clear_inputs();
    step();

    // writes to $0 never create a hazard
    pulse_reset();
    clear_inputs();
    IDIsBranch = 1; IDUsesRs = 1; IDUsesRt = 1; IDBranchTaken = 1;
    EXRegWrite = 1; EXRd = 5'd0;
    step();
    clear_inputs();
    step();

    // unconditional jump with no hazard
    clear_inputs();
    IDIsJump = 1;
    step();
    clear_inputs();
    step();

    // reset during the second hold cycle abandons the stall
    pulse_reset();
    lw_beq_setup();
    step();
    lw_moves_to_mem();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    MEMMemRead = 0; MEMRd = 0;
    step();
    clear_inputs();
    step();

    // random traffic on a narrow register range so hazards are frequent
    for (int i = 0; i < 2000; i++) begin
      IDRs = 5'($urandom_range(0, 3));
      IDRt = 5'($urandom_range(0, 3));
      EXRd = 5'($urandom_range(0, 3));
      MEMRd = 5'($urandom_range(0, 3));
      IDUsesRs = 1'($urandom);
      IDUsesRt = 1'($urandom);
      IDIsBranch = ($urandom_range(0, 3) == 0);
      IDIsJump = !IDIsBranch && ($urandom_range(0, 5) == 0);
      IDBranchTaken = 1'($urandom);
      EXMemRead = 1'($urandom);
      EXRegWrite = EXMemRead || 1'($urandom);
      MEMMemRead = 1'($urandom);
      reset = ($urandom_range(0, 63) != 0);
      step();
    end
    reset = 1'b1;

    // persistent load-use hazard drives the stall counter into saturation
    pulse_reset();
    clear_inputs();
    IDUsesRs = 1; IDRs = 5'd9; EXMemRead = 1; EXRegWrite = 1; EXRd = 5'd9;
    for (int i = 0; i < 65540; i++) step();
    clear_inputs();
    IDIsJump = 1;
    step();
    clear_inputs();
    step();
    step();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
